// File: rtl/regfile_mp_if.sv
// regfile_mp_if: client-side bus of the multi-port register file.
//
// Groups the clear control, the NRD read ports, the NWR write ports and the
// scoreboard allocation port. The master modport belongs to the pipeline that
// uses the file. The slave modport belongs to regfile_mp.
//
//   clear_req  (m->s)  one-cycle pulse that starts a clear walk
//   ready      (s->m)  file usable; low while a clear walk runs
//   rd_addr    (m->s)  NRD packed read addresses, AW bits each
//   rd_data    (s->m)  NRD packed read data, XLEN bits each
//   rd_pending (s->m)  per-read-port scoreboard bit
//   wr_en      (m->s)  per-write-port enable; port NWR-1 is the youngest
//   wr_addr    (m->s)  NWR packed write addresses
//   wr_data    (m->s)  NWR packed write data
//   alloc_en   (m->s)  mark alloc_addr as awaiting writeback
//   alloc_addr (m->s)  register being allocated
interface regfile_mp_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic                 clear_req;
    logic                 ready;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_pending;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 alloc_en;
    logic [AW-1:0]        alloc_addr;

    modport master (
        output clear_req, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  ready, rd_data, rd_pending
    );

    modport slave (
        input  clear_req, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output ready, rd_data, rd_pending
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a pending-writeback scoreboard.
//
// NRD combinational read ports, NWR write ports (highest-index port wins on
// an address collision), register 0 hardwired to zero and never pending.
// After reset, or on clear_req, the contents are zeroed by a walk that clears
// one entry per cycle; ready is low and the file ignores writes and allocs
// for the duration of the walk.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset; restarts the clear walk
//   bus  regfile_mp_if slave modport (read/write/alloc/clear signals)
//
// Build option: define REGFILE_MP_BYPASS_EN to forward same-cycle write data
// to matching read ports (pending reads as 0 for a forwarded read).
module regfile_mp #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);

    typedef enum logic {StIdle, StClear} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [AW-1:0]     r_cnt;
    logic [AW-1:0]     w_cnt_d;
    logic [XLEN-1:0]   r_data [NREGS];
    logic [NREGS-1:0]  r_pend;
    logic [NREGS-1:0]  w_pend_d;
    logic              w_ready;
    logic              w_last;

    logic [AW-1:0]     w_raddr [NRD];
    logic [AW-1:0]     w_waddr [NWR];
    logic [XLEN-1:0]   w_wdata [NWR];
    logic [NRD*XLEN-1:0] w_rd_data;
    logic [NRD-1:0]    w_rd_pend;

    for (genvar i = 0; i < NRD; i++) begin : g_rd_unpack
        assign w_raddr[i] = bus.rd_addr[i*AW +: AW];
    end

    for (genvar p = 0; p < NWR; p++) begin : g_wr_unpack
        assign w_waddr[p] = bus.wr_addr[p*AW +: AW];
        assign w_wdata[p] = bus.wr_data[p*XLEN +: XLEN];
    end

    assign w_ready = (r_state == StIdle);
    assign w_last  = (r_cnt == AW'(NREGS - 1));

    // Next state: the walk counter wraps to zero on its own after the last
    // entry because NREGS is a power of two.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (bus.clear_req) begin
                    w_state_d = StClear;
                    w_cnt_d   = '0;
                end
            end
            StClear: begin
                w_cnt_d = r_cnt + 1'b1;
                if (w_last) begin
                    w_state_d = StIdle;
                end
            end
        endcase
    end

    // Scoreboard: writes clear, then alloc sets, so a same-edge alloc of the
    // written register leaves it pending for the newer producer.
    always_comb begin
        w_pend_d = r_pend;
        if (w_ready) begin
            if (bus.clear_req) begin
                w_pend_d = '0;
            end else begin
                for (int p = 0; p < NWR; p++) begin
                    if (bus.wr_en[p]) begin
                        w_pend_d[w_waddr[p]] = 1'b0;
                    end
                end
                if (bus.alloc_en) begin
                    w_pend_d[bus.alloc_addr] = 1'b1;
                end
            end
        end
        w_pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StClear;
            r_cnt   <= '0;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_pend  <= w_pend_d;
        end
    end

    // Data array has no reset of its own; the walk zeroes it. Ports are
    // visited in ascending order so the youngest port's write lands last.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (r_state == StClear) begin
                r_data[r_cnt] <= '0;
            end else begin
                for (int p = 0; p < NWR; p++) begin
                    if (bus.wr_en[p] && (w_waddr[p] != '0)) begin
                        r_data[w_waddr[p]] <= w_wdata[p];
                    end
                end
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_pend = '0;
        for (int i = 0; i < NRD; i++) begin
            if (w_ready && (w_raddr[i] != '0)) begin
                w_rd_data[i*XLEN +: XLEN] = r_data[w_raddr[i]];
                w_rd_pend[i]              = r_pend[w_raddr[i]];
`ifdef REGFILE_MP_BYPASS_EN
                for (int p = 0; p < NWR; p++) begin
                    if (bus.wr_en[p] && (w_waddr[p] == w_raddr[i])) begin
                        w_rd_data[i*XLEN +: XLEN] = w_wdata[p];
                        w_rd_pend[i]              = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign bus.ready      = w_ready;
    assign bus.rd_data    = w_rd_data;
    assign bus.rd_pending = w_rd_pend;
endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed corner sequences, a table of write /
// alloc / read vectors, and randomized traffic against a behavioural model.
module tb_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;
`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: array contents, pending flags, remaining walk length.
    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_pend [NREGS];
    int              m_walk = NREGS;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [AW-1:0] a;
        if (!rst) begin
            m_walk = NREGS;
            for (int r = 0; r < NREGS; r++) m_pend[r] = 1'b0;
        end else if (m_walk > 0) begin
            m_mem[NREGS - m_walk] = '0;
            m_walk--;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                a = bus.wr_addr[p*AW +: AW];
                if (bus.wr_en[p] && a != 0) begin
                    m_mem[a]  = bus.wr_data[p*XLEN +: XLEN];
                    m_pend[a] = 1'b0;
                end
            end
            if (bus.alloc_en && bus.alloc_addr != 0) m_pend[bus.alloc_addr] = 1'b1;
            if (bus.clear_req) begin
                m_walk = NREGS;
                for (int r = 0; r < NREGS; r++) m_pend[r] = 1'b0;
            end
        end
    endtask

    task automatic model_read(input logic [AW-1:0] addr, output logic [XLEN-1:0] d,
                              output logic pnd);
        d   = '0;
        pnd = 1'b0;
        if (m_walk == 0 && addr != 0) begin
            d   = m_mem[addr];
            pnd = m_pend[addr];
            if (BYP) begin
                for (int p = 0; p < NWR; p++) begin
                    if (bus.wr_en[p] && bus.wr_addr[p*AW +: AW] == addr) begin
                        d   = bus.wr_data[p*XLEN +: XLEN];
                        pnd = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        logic [XLEN-1:0] d;
        logic            pnd;
        check("ready", 64'(bus.ready), 64'(m_walk == 0));
        for (int i = 0; i < NRD; i++) begin
            model_read(bus.rd_addr[i*AW +: AW], d, pnd);
            check($sformatf("rd_data%0d", i), 64'(bus.rd_data[i*XLEN +: XLEN]), 64'(d));
            check($sformatf("rd_pending%0d", i), 64'(bus.rd_pending[i]), 64'(pnd));
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [AW-1:0] wa0, input logic [31:0] wd0,
                         input logic [AW-1:0] wa1, input logic [31:0] wd1, input logic ae,
                         input logic [AW-1:0] aa, input logic [AW-1:0] ra0,
                         input logic [AW-1:0] ra1, input logic cr);
        bus.wr_en      = we;
        bus.wr_addr    = {wa1, wa0};
        bus.wr_data    = {wd1, wd0};
        bus.alloc_en   = ae;
        bus.alloc_addr = aa;
        bus.rd_addr    = {ra1, ra0};
        bus.clear_req  = cr;
    endtask

    task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, ra0, ra1, 1'b0);
    endtask

    // One clock: model follows the DUT on the edge; returns at the falling edge.
    task automatic clock();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Clocks until ready is seen; returns the number of edges taken.
    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.ready && n < 100) begin
            clock();
            n++;
        end
    endtask

    function automatic logic [XLEN-1:0] rd(input int i);
        return bus.rd_data[i*XLEN +: XLEN];
    endfunction

    typedef struct {
        logic [1:0]      we;
        logic [AW-1:0]   wa0;
        logic [31:0]     wd0;
        logic [AW-1:0]   wa1;
        logic [31:0]     wd1;
        logic            ae;
        logic [AW-1:0]   aa;
        logic [AW-1:0]   ra0;
        logic [AW-1:0]   ra1;
        logic [31:0]     ed0;
        logic [31:0]     ed1;
        logic            ep0;
        logic            ep1;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int n;
        vecs[0] = '{2'b01, 5'd1, 32'h1111_1111, 5'd0, 32'h0, 1'b0, 5'd0,
                    5'd1, 5'd2, 32'h1111_1111, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{2'b10, 5'd0, 32'h0, 5'd2, 32'h2222_2222, 1'b1, 5'd3,
                    5'd2, 5'd3, 32'h2222_2222, 32'h0, 1'b0, 1'b1};
        vecs[2] = '{2'b11, 5'd3, 32'h3333_3333, 5'd4, 32'h4444_4444, 1'b0, 5'd0,
                    5'd3, 5'd4, 32'h3333_3333, 32'h4444_4444, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 5'd1, 32'hAAAA_AAAA, 5'd1, 32'hBBBB_BBBB, 1'b1, 5'd1,
                    5'd1, 5'd2, 32'hBBBB_BBBB, 32'h2222_2222, 1'b1, 1'b0};
        vecs[4] = '{2'b01, 5'd0, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b1, 5'd0,
                    5'd0, 5'd1, 32'h0, 32'hBBBB_BBBB, 1'b0, 1'b1};
        vecs[5] = '{2'b00, 5'd2, 32'h0000_FFFF, 5'd0, 32'h0, 1'b1, 5'd2,
                    5'd2, 5'd31, 32'h2222_2222, 32'h0, 1'b1, 1'b0};
        vecs[6] = '{2'b10, 5'd0, 32'h0, 5'd31, 32'h1234_5678, 1'b1, 5'd2,
                    5'd2, 5'd31, 32'h2222_2222, 32'h1234_5678, 1'b1, 1'b0};
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
        end

        // Reset held three cycles, then the walk.
        rst = 1'b0;
        idle(0, 0);
        repeat (3) clock();
        check("ready_in_reset", 64'(bus.ready), 64'd0);
        rst = 1'b1;
        wait_ready(n);
        check("reset_walk_len", 64'(n), 64'd32);
        idle(5, 31);
        #1;
        check("r5_after_reset", 64'(rd(0)), 64'd0);
        check("r31_after_reset", 64'(rd(1)), 64'd0);

        // Clear request wipes a written register.
        drive(2'b01, 5, 32'hDEAD, 0, 0, 1'b0, 0, 0, 0, 1'b0);
        clock();
        idle(5, 0);
        #1;
        check("r5_written", 64'(rd(0)), 64'hDEAD);
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5, 0, 1'b1);
        clock();
        idle(5, 0);
        #1;
        check("ready_drop_on_clear", 64'(bus.ready), 64'd0);
        wait_ready(n);
        check("clear_walk_len", 64'(n), 64'd32);
        #1;
        check("r5_after_clear", 64'(rd(0)), 64'd0);

        // Write priority and register 0.
        drive(2'b11, 7, 32'h1111, 7, 32'h2222, 1'b0, 0, 0, 0, 1'b0);
        clock();
        idle(7, 0);
        #1;
        check("r7_priority", 64'(rd(0)), 64'h2222);
        drive(2'b01, 0, 32'hFFFF, 0, 0, 1'b0, 0, 0, 0, 1'b0);
        clock();
        idle(0, 7);
        #1;
        check("r0_zero", 64'(rd(0)), 64'd0);

        // Same-cycle read of a register being written.
        drive(2'b10, 0, 0, 3, 32'hABCD, 1'b0, 0, 3, 0, 1'b0);
        #1;
        check("bypass_same_cycle", 64'(rd(0)), BYP ? 64'hABCD : 64'd0);
        clock();
        idle(3, 0);
        #1;
        check("r3_next_cycle", 64'(rd(0)), 64'hABCD);

        // Scoreboard sequences on r9.
        drive(2'b00, 0, 0, 0, 0, 1'b1, 9, 9, 0, 1'b0);
        #1;
        check("r9_pend_before_alloc", 64'(bus.rd_pending[0]), 64'd0);
        clock();
        idle(9, 0);
        #1;
        check("r9_pend_after_alloc", 64'(bus.rd_pending[0]), 64'd1);
        drive(2'b01, 9, 32'h99, 0, 0, 1'b0, 0, 9, 0, 1'b0);
        #1;
        check("r9_pend_during_write", 64'(bus.rd_pending[0]), BYP ? 64'd0 : 64'd1);
        clock();
        idle(9, 0);
        #1;
        check("r9_pend_after_write", 64'(bus.rd_pending[0]), 64'd0);
        check("r9_data_after_write", 64'(rd(0)), 64'h99);
        drive(2'b01, 9, 32'h77, 0, 0, 1'b1, 9, 0, 0, 1'b0);
        clock();
        idle(9, 0);
        #1;
        check("r9_alloc_beats_write", 64'(bus.rd_pending[0]), 64'd1);
        check("r9_data_alloc_write", 64'(rd(0)), 64'h77);
        drive(2'b00, 0, 0, 0, 0, 1'b1, 0, 0, 0, 1'b0);
        clock();
        idle(0, 0);
        #1;
        check("r0_never_pending", 64'(bus.rd_pending[0]), 64'd0);

        // Writes and allocs during a walk are dropped.
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 4, 0, 1'b1);
        clock();
        n = 0;
        while (!bus.ready && n < 100) begin
            drive(2'b01, 4, 32'hBEEF, 0, 0, 1'b1, 4, 4, 0, 1'b0);
            clock();
            n++;
        end
        idle(4, 0);
        #1;
        check("ignored_walk_len", 64'(n), 64'd32);
        check("r4_not_written", 64'(rd(0)), 64'd0);
        check("r4_not_pending", 64'(bus.rd_pending[0]), 64'd0);

        // Reset at cnt=10 restarts the walk.
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b1);
        clock();
        idle(0, 0);
        repeat (10) clock();
        rst = 1'b0;
        clock();
        rst = 1'b1;
        wait_ready(n);
        check("midwalk_reset_len", 64'(n), 64'd32);

        // Table vectors: apply on one edge, read back on the next cycle.
        for (int v = 0; v < 7; v++) begin
            drive(vecs[v].we, vecs[v].wa0, vecs[v].wd0, vecs[v].wa1, vecs[v].wd1,
                  vecs[v].ae, vecs[v].aa, 0, 0, 1'b0);
            clock();
            idle(vecs[v].ra0, vecs[v].ra1);
            #1;
            check($sformatf("vec%0d_rd0", v), 64'(rd(0)), 64'(vecs[v].ed0));
            check($sformatf("vec%0d_rd1", v), 64'(rd(1)), 64'(vecs[v].ed1));
            check($sformatf("vec%0d_pend0", v), 64'(bus.rd_pending[0]), 64'(vecs[v].ep0));
            check($sformatf("vec%0d_pend1", v), 64'(bus.rd_pending[1]), 64'(vecs[v].ep1));
        end

        // Randomized traffic against the model; small address range for collisions.
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 299) != 0);
            drive(2'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 99) == 0));
            #1;
            check_all();
            clock();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file, successor to the single-write integer regfile. Targets the dual-issue pipeline's decode/writeback stages.
- Provides NRD read ports and NWR write ports, with an ordered write-priority rule and optional same-cycle write-through bypass.
- Maintains a per-register pending scoreboard for hazard detection.
- After reset, or on request, zeroes all entries with a sequential clear walk instead of a one-cycle bulk reset.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, minimum 4. AW = $clog2(NREGS).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports. Port NWR-1 is the youngest in program order.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset.
- clear_req  in  1  one-cycle pulse; starts a clear walk.
- ready  out  1  high when the file is usable; low during a clear walk.
- rd_addr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- rd_pending  out  NRD  high when the addressed register awaits a writeback.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- alloc_en  in  1  marks alloc_addr as pending (producer issued).
- alloc_addr  in  AW  register being allocated.

Behaviour:
- Reset (clock edge with rst=0):
  - State <= CLEAR, clear counter cnt <= 0, all pending bits <= 0.
  - Data contents are not reset in that cycle; the walk zeroes them.
- FSM states: IDLE and CLEAR.
  - ready = (state == IDLE).
  - CLEAR: each cycle writes data[cnt] <= 0 and increments cnt. At cnt == NREGS-1, the last entry is zeroed and state <= IDLE.
  - ready therefore rises exactly NREGS cycles after the first edge with rst=1.
  - IDLE: clear_req=1 -> CLEAR, cnt <= 0, all pending <= 0. clear_req is ignored while in CLEAR.
  - rst=0 mid-walk restarts the walk from cnt=0.
- While ready=0:
  - wr_en and alloc_en are ignored.
  - rd_data reads 0 and rd_pending reads 0.
- Register 0:
  - Always reads 0 and is never pending.
  - Writes and allocs to address 0 are dropped.
- Writes: on an edge with ready=1, each enabled port with a nonzero address writes its data.
  - When several enabled ports target the same address, the highest-index port wins.
- Scoreboard:
  - An enabled write clears pending[wr_addr].
  - alloc_en sets pending[alloc_addr].
  - If alloc and write hit the same register on the same edge, the alloc wins and pending stays 1 (the newer producer).
  - Allocating an already-pending register keeps it at 1.
- Reads: combinational.
  - rd_data[i] = data[rd_addr[i]], subject to the bypass rule below.
  - rd_pending[i] = pending[rd_addr[i]], subject to the bypass rule below.
- Width: AW-bit addresses always index within NREGS, so no out-of-range case exists.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined:
  - Write-through bypass: if any enabled write port this cycle matches a nonzero rd_addr[i], rd_data[i] returns that write data. The highest-index matching port is used.
  - rd_pending[i] is forced to 0 for that read.
- Undefined:
  - Reads return the registered array contents and the registered pending bit only.
  - The new value is visible from the cycle after the write edge.

Test Plan:
- Reset/clear: hold rst=0 for 3 cycles, release -> ready=0 for exactly 32 cycles then 1; all reads return 0. Pulse clear_req after writing r5=0xDEAD -> ready drops for 32 cycles; r5 reads 0 afterwards.
- Write priority: wr_en=2'b11, both ports to addr 7, port0=0x1111, port1=0x2222 -> next cycle r7 reads 0x2222. Write port0 to r0 with 0xFFFF -> r0 still reads 0.
- Bypass (macro defined): write r3=0xABCD on port1 while rd_addr0=3 -> rd_data0=0xABCD in the same cycle. With the macro undefined -> old value (0) in that cycle, 0xABCD the next cycle.
- Scoreboard: alloc r9 -> rd_pending for r9 = 1 next cycle. Write r9 -> pending 0 after the edge. Alloc and write r9 on the same edge -> pending stays 1. Alloc r0 -> pending 0.
- Ignored during clear: wr_en and alloc_en to r4 while ready=0 -> after ready=1, r4 reads 0 and is not pending.
- Reset mid-walk: assert rst=0 at cnt=10 for one cycle -> walk restarts; ready rises 32 cycles after rst returns high.
